// File: rtl/maroc_sc_pkg.sv
// Shared MAROC slow-control definitions: frame length, transmitter state
// encodings and the readback checker FSM states.
package maroc_sc_pkg;

  localparam int MAROC_FRAME_LEN = 829;

  typedef enum logic [1:0] {
    TX_IDLE            = 2'd0,
    TX_PREPARE_TO_SEND = 2'd1,
    TX_SENDING         = 2'd2,
    TX_FINAL           = 2'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RB_IDLE,
    RB_WAIT,
    RB_SKIPPING,
    RB_CAPTURE,
    RB_DONE
  } rb_state_e;

endpackage

// File: rtl/maroc_sc_readback.sv
// Captures the MAROC Q_SC readback during SENDING and compares it bit by bit
// against the frame snapshotted at arm time; publishes registered results.
module maroc_sc_readback
  import maroc_sc_pkg::*;
#(
  parameter int FRAME_LEN = MAROC_FRAME_LEN,
  parameter int SKIP      = 1,
  parameter int CNT_W     = 10
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 arm_in,
  input  logic [1:0]           state_in,
  input  logic                 Q_SC_in,
  input  logic [FRAME_LEN-1:0] expected_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 match_out,
  output logic                 aborted_out,
  output logic [CNT_W-1:0]     err_count_out,
  output logic [CNT_W-1:0]     first_err_idx_out,
  output logic [FRAME_LEN-1:0] captured_out
);

  rb_state_e            state_q, state_d;
  logic [FRAME_LEN-1:0] snap_q, snap_d;
  logic [FRAME_LEN-1:0] cap_q, cap_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [CNT_W-1:0]     first_q, first_d;
  logic [CNT_W-1:0]     bit_q, bit_d;
  logic [CNT_W-1:0]     skip_q, skip_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 match_q, match_d;
  logic                 abort_q, abort_d;
  logic [CNT_W-1:0]     err_out_q, err_out_d;
  logic [CNT_W-1:0]     first_out_q, first_out_d;
  logic [FRAME_LEN-1:0] cap_out_q, cap_out_d;

  logic sending, capture_en, finish, aborting;

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    cap_d       = cap_q;
    err_d       = err_q;
    first_d     = first_q;
    bit_d       = bit_q;
    skip_d      = skip_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    match_d     = match_q;
    abort_d     = abort_q;
    err_out_d   = err_out_q;
    first_out_d = first_out_q;
    cap_out_d   = cap_out_q;
    sending     = (state_in == TX_SENDING);
    capture_en  = 1'b0;
    finish      = 1'b0;
    aborting    = 1'b0;

    unique case (state_q)
      RB_IDLE: begin
        if (arm_in) begin
          snap_d  = expected_in;
          cap_d   = '0;
          err_d   = '0;
          first_d = '1;
          bit_d   = '0;
          busy_d  = 1'b1;
          state_d = RB_WAIT;
        end
      end
      // The first SENDING cycle counts as skip cycle 0, so SKIP==0 captures here.
      RB_WAIT: begin
        if (sending) begin
          if (SKIP == 0) begin
            capture_en = 1'b1;
          end else if (SKIP == 1) begin
            state_d = RB_CAPTURE;
          end else begin
            skip_d  = CNT_W'(1);
            state_d = RB_SKIPPING;
          end
        end
      end
      RB_SKIPPING: begin
        if (!sending) begin
          aborting = 1'b1;
        end else if (skip_q == CNT_W'(SKIP - 1)) begin
          state_d = RB_CAPTURE;
        end else begin
          skip_d = skip_q + CNT_W'(1);
        end
      end
      RB_CAPTURE: begin
        if (!sending) aborting = 1'b1;
        else          capture_en = 1'b1;
      end
      RB_DONE: state_d = RB_IDLE;
      default: state_d = RB_IDLE;
    endcase

    if (capture_en) begin
      cap_d  = {Q_SC_in, cap_q[FRAME_LEN-1:1]};
      snap_d = snap_q >> 1;
      if (Q_SC_in != snap_q[0]) begin
        err_d = err_q + CNT_W'(1);
        if (err_q == '0) first_d = bit_q;
      end
      bit_d = bit_q + CNT_W'(1);
      if (bit_q == CNT_W'(FRAME_LEN - 1)) finish = 1'b1;
      else                                state_d = RB_CAPTURE;
    end

    // Results are published on the transition into DONE so they are valid with done.
    if (finish || aborting) begin
      state_d     = RB_DONE;
      busy_d      = 1'b0;
      done_d      = 1'b1;
      abort_d     = aborting;
      match_d     = !aborting && (err_d == '0);
      err_out_d   = err_d;
      first_out_d = first_d;
      cap_out_d   = cap_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= RB_IDLE;
      snap_q      <= '0;
      cap_q       <= '0;
      err_q       <= '0;
      first_q     <= '1;
      bit_q       <= '0;
      skip_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      abort_q     <= 1'b0;
      err_out_q   <= '0;
      first_out_q <= '1;
      cap_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      cap_q       <= cap_d;
      err_q       <= err_d;
      first_q     <= first_d;
      bit_q       <= bit_d;
      skip_q      <= skip_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      match_q     <= match_d;
      abort_q     <= abort_d;
      err_out_q   <= err_out_d;
      first_out_q <= first_out_d;
      cap_out_q   <= cap_out_d;
    end
  end

  assign busy_out          = busy_q;
  assign done_out          = done_q;
  assign match_out         = match_q;
  assign aborted_out       = abort_q;
  assign err_count_out     = err_out_q;
  assign first_err_idx_out = first_out_q;
  assign captured_out      = cap_out_q;

endmodule

// File: doc/maroc_sc_readback.md
# maroc_sc_readback

Readback checker placed directly downstream of the MAROC slow-control transmitter. It samples the chip's serial slow-control output, Q_SC, while the transmitter shifts a frame in. It compares the 829 bits clocked out against an expected frame, which is the frame loaded on the previous transmission. It reports match/mismatch, the error count, the first failing bit index and the captured frame, so firmware can confirm the MAROC configuration actually latched.

## Interface
Parameters:
- FRAME_LEN, 829: slow-control frame length in bits.
- SKIP, 1: cycles between the first SENDING cycle and the first valid Q_SC bit.
- CNT_W, 10: width of counters and indices; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk_in  in  1  5 MHz clock, same as the transmitter clk_in.
- reset_in  in  1  synchronous, active-high reset.
- arm_in  in  1  one-cycle pulse; snapshots expected_in and waits for the next SENDING phase.
- state_in  in  2  transmitter state_out (0 IDLE, 1 PREPARE_TO_SEND, 2 SENDING, 3 FINAL).
- Q_SC_in  in  1  serial readback from MAROC, already synchronised to clk_in.
- expected_in  in  FRAME_LEN  expected frame, same bit order as the transmitter frame (bit 0 shifted first).
- busy_out  out  1  high from arm until done.
- done_out  out  1  one-cycle pulse at end of check.
- match_out  out  1  1 when the last completed check had zero errors and was not aborted.
- aborted_out  out  1  last check ended because SENDING ended early.
- err_count_out  out  CNT_W  mismatching bit count of the last check.
- first_err_idx_out  out  CNT_W  index of the first mismatching bit; all-ones if there were none.
- captured_out  out  FRAME_LEN  bits captured in the last check; bit k is the k-th captured bit.

## Operation
FSM states and transitions:
- IDLE: on arm_in, load snap <= expected_in and go to WAIT.
- WAIT: when state_in == 2, go to SKIPPING with skip_ctr = 0. If SKIP == 0, go directly to CAPTURE.
- SKIPPING: increment skip_ctr each cycle; go to CAPTURE when skip_ctr == SKIP-1.
- CAPTURE: each cycle, sample bit = Q_SC_in.
  - Shift captured: captured <= {bit, captured[FRAME_LEN-1:1]}.
  - Compare bit with snap[0], then shift snap right by one.
  - On mismatch, increment err_count. If this is the first error, first_err_idx <= bit_ctr.
  - Increment bit_ctr.
  - When bit_ctr == FRAME_LEN-1 is being sampled, go to DONE next cycle.
- DONE: for one cycle, pulse done_out, update match_out and aborted_out, then return to IDLE.

Result registers:
- err_count, first_err_idx and captured are cleared when WAIT is entered.
- Their output copies hold the last completed result until the next done.

Boundary cases:
- If state_in != 2 during SKIPPING or CAPTURE before FRAME_LEN bits are taken, go to DONE with aborted_out=1 and match_out=0. The partial captured and err_count values are still published.
- arm_in while busy is ignored.
- arm_in in the same cycle as a done pulse is ignored; the block is in DONE.
- SENDING cycles after FRAME_LEN captures are ignored. The transmitter stays in SENDING at least FRAME_LEN+1 cycles.
- err_count needs no saturation; its maximum is FRAME_LEN.
- reset_in mid-check returns the FSM to IDLE and clears everything to reset values, with no done pulse.

## Timing
- Reset values:
  - busy_out, done_out, match_out, aborted_out: 0.
  - err_count_out: 0.
  - first_err_idx_out: all-ones.
  - captured_out: 0.
- busy_out rises the cycle after arm_in and falls in the same cycle done_out is high.
- Capture window: cycles c0+SKIP through c0+SKIP+FRAME_LEN-1, where c0 is the first cycle with state_in == 2.
- done_out asserts at c0+SKIP+FRAME_LEN. All result outputs are valid in that cycle and stay stable afterwards.
- The end-of-check decision is made with no combinational path from Q_SC_in to outputs; all outputs are registered.

## Structure
- Shared package maroc_sc_pkg holds:
  - the frame length 829,
  - the transmitter state encodings IDLE/PREPARE_TO_SEND/SENDING/FINAL (also used by the transmitter),
  - the readback FSM enum.
- No sub-module. The snap/captured shift registers and counters are in a single module.

## Test plan
- SKIP=1; expected all-zeros; Q_SC model returns the previously loaded all-zeros frame -> done at c0+830, match=1, err_count=0, first_err_idx=1023.
- Expected = alternating 1010…; model flips bit 5 and bit 700 -> err_count=2, first_err_idx=5, match=0, captured differs from expected only at 5 and 700.
- Expected = all-ones, Q_SC stuck 0 -> err_count=829, first_err_idx=0.
- state_in drops from 2 to 3 after 400 captured bits -> aborted=1, match=0, err_count counts only those 400 bits, done one cycle after the drop.
- arm_in pulsed again mid-CAPTURE, and reset_in asserted at bit 300 -> the second arm is ignored; after reset all outputs are at reset values and there is no done pulse.
- SKIP=0 and SKIP=3 -> the first captured bit is the one at c0 and at c0+3 respectively (checked with a marker bit at position 0).
